// File: rtl/instr_fetch_if.sv
// Instruction memory request/acknowledge bus between the fetch stage and imem.
// master = fetch stage, slave = memory.
interface instr_fetch_if;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ack;

  modport master (output imem_addr, output imem_req,
                  input  imem_rdata, input imem_ack);
  modport slave  (input  imem_addr, input imem_req,
                  output imem_rdata, output imem_ack);
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: imem request/ack transaction into an instruction register.
// Optional FETCH_TIMEOUT_EN compiles in a REQ-cycle watchdog that faults a hung memory.
//
// state | meaning
// IDLE  | no fetch outstanding, IR not valid for the controller
// REQ   | imem_req high, waiting for imem_ack
// HOLD  | IR holds the fetched word, instr_valid high
// FAULT | misaligned PC (or memory timeout); left only by rst
module instr_fetch #(
  parameter logic [31:0] INITIAL_PC = 32'h0040_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
  parameter int          TIMEOUT    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          pc_in,
  input  logic                 fetch_req,
  instr_fetch_if.master        imem,
  output logic [31:0]          instr,
  output logic                 instr_valid,
  output logic                 busy,
  output logic                 fault,
  output logic [31:0]          fetch_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_timeout
    $error("instr_fetch: TIMEOUT must be in 1..255");
  end

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic [31:0] ir_q, ir_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        fault_q, fault_d;
  logic [31:0] count_q, count_d;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] tmo_q, tmo_d;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    req_d   = req_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    count_d = count_q;
`ifdef FETCH_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      S_IDLE, S_HOLD: begin
        if (fetch_req) begin
          valid_d = 1'b0;
          if (pc_in[1:0] == 2'b00) begin
            addr_d  = pc_in;
            req_d   = 1'b1;
            state_d = S_REQ;
`ifdef FETCH_TIMEOUT_EN
            tmo_d   = 8'd0;
`endif
          end else begin
            req_d   = 1'b0;
            state_d = S_FAULT;
          end
        end
      end
      S_REQ: begin
        // ack wins over a timeout expiring on the same edge
        if (imem.imem_ack) begin
          ir_d    = imem.imem_rdata;
          valid_d = 1'b1;
          req_d   = 1'b0;
          count_d = count_q + 32'd1;
          state_d = S_HOLD;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          req_d   = 1'b0;
          state_d = S_FAULT;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`endif
      end
      default: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
    busy_d  = (state_d == S_REQ);
    fault_d = (state_d == S_FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= INITIAL_PC;
      req_q   <= 1'b0;
      ir_q    <= NOP_INSTR;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
      count_q <= 32'd0;
`ifdef FETCH_TIMEOUT_EN
      tmo_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
      count_q <= count_d;
`ifdef FETCH_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign imem.imem_addr = addr_q;
  assign imem.imem_req  = req_q;
  assign instr          = ir_q;
  assign instr_valid    = valid_q;
  assign busy           = busy_q;
  assign fault          = fault_q;
  assign fetch_count    = count_q;

endmodule
